// File: rtl/reg_sequencer_pkg.sv
// Shared types for the register-file sequencer: register port enums,
// opcode/state encodings and instruction field positions.
package reg_sequencer_pkg;

  typedef enum logic {
    REG_IDLE  = 1'b0,
    REG_WRITE = 1'b1
  } registers_op_e;

  typedef enum logic [1:0] {
    REG_SEL_0 = 2'd0,
    REG_SEL_1 = 2'd1,
    REG_SEL_2 = 2'd2,
    REG_SEL_3 = 2'd3
  } register_sel_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_LDI = 4'd7,
    OP_INC = 4'd8,
    OP_SHL = 4'd9
  } seq_opcode_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    IMM   = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } seq_state_e;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 4;
  localparam int unsigned RD_MSB  = 3;
  localparam int unsigned RD_LSB  = 2;
  localparam int unsigned RS_MSB  = 1;
  localparam int unsigned RS_LSB  = 0;

  function automatic logic is_legal_op(logic [3:0] op);
    return (op <= 4'd9);
  endfunction

  // Ops whose writeback also updates zero/carry; MOV and LDI do not.
  function automatic logic is_alu_op(seq_opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC, OP_SHL: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_sequencer_alu.sv
// Combinational ALU for the sequencer; evaluated one bit wider than the data
// so the top bit carries the carry/borrow out.
module seq_alu
  import reg_sequencer_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  seq_opcode_e    opcode_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [W-1:0]   result_o,
  output logic           carry_o
);

  logic [W:0] wide;

  always_comb begin
    wide = '0;
    case (opcode_i)
      OP_MOV:  wide = {1'b0, b_i};
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      OP_XOR:  wide = {1'b0, a_i ^ b_i};
      OP_INC:  wide = {1'b0, a_i} + (W+1)'(1);
      OP_SHL:  wide = {a_i, 1'b0};
      default: wide = '0;
    endcase
    result_o = wide[W-1:0];
    carry_o  = wide[W];
  end

endmodule

// File: rtl/reg_sequencer.sv
// Instruction sequencer driving a 4-entry register file: fetch/decode over
// valid/ready, operand read, ALU execute, single-cycle writeback.
module reg_sequencer
  import reg_sequencer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_BUS_WIDTH-1:0] instr_data,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [DATA_BUS_WIDTH-1:0] reg_1_in,
  input  logic [DATA_BUS_WIDTH-1:0] reg_2_in,
  output registers_op_e             reg_op,
  output register_sel_e             reg_in_sel,
  output register_sel_e             reg_1_out_sel,
  output register_sel_e             reg_2_out_sel,
  output logic [DATA_BUS_WIDTH-1:0] reg_data_out,
  output logic                      flag_zero,
  output logic                      flag_carry,
  output logic                      illegal,
  output logic                      busy
);

  seq_state_e                state_q, state_d;
  logic [INSTR_W-1:0]        instr_q, instr_d;
  logic [DATA_BUS_WIDTH-1:0] result_q, result_d;
  logic                      zero_q, zero_d;
  logic                      carry_q, carry_d;
  logic                      carry_pend_q, carry_pend_d;
  logic                      illegal_q, illegal_d;

  seq_opcode_e               op_q;
  logic [3:0]                fetch_op;
  logic [DATA_BUS_WIDTH-1:0] alu_result;
  logic                      alu_carry;

  assign op_q     = seq_opcode_e'(instr_q[OP_MSB:OP_LSB]);
  assign fetch_op = instr_data[OP_MSB:OP_LSB];

  seq_alu #(
    .W (DATA_BUS_WIDTH)
  ) u_alu (
    .opcode_i (op_q),
    .a_i      (reg_1_in),
    .b_i      (reg_2_in),
    .result_o (alu_result),
    .carry_o  (alu_carry)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      instr_q      <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      carry_pend_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      carry_pend_q <= carry_pend_d;
      illegal_q    <= illegal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    result_d     = result_q;
    zero_d       = zero_q;
    carry_d      = carry_q;
    carry_pend_d = carry_pend_q;
    illegal_d    = 1'b0;
    instr_ready  = 1'b0;
    reg_op       = REG_IDLE;
    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr_data[INSTR_W-1:0];
          if (!is_legal_op(fetch_op))
            illegal_d = 1'b1;
          else if (fetch_op == OP_LDI)
            state_d = IMM;
          else if (fetch_op != OP_NOP)
            state_d = EXEC;
        end
      end
      IMM: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          result_d = instr_data;
          state_d  = WRITE;
        end
      end
      EXEC: begin
        // Carry is held until writeback so flags change together with the write.
        result_d     = alu_result;
        carry_pend_d = alu_carry;
        state_d      = WRITE;
      end
      WRITE: begin
        reg_op = REG_WRITE;
        if (is_alu_op(op_q)) begin
          zero_d  = (result_q == '0);
          carry_d = carry_pend_q;
        end
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign reg_in_sel    = register_sel_e'(instr_q[RD_MSB:RD_LSB]);
  assign reg_1_out_sel = register_sel_e'(instr_q[RD_MSB:RD_LSB]);
  assign reg_2_out_sel = register_sel_e'(instr_q[RS_MSB:RS_LSB]);
  assign reg_data_out  = result_q;
  assign flag_zero     = zero_q;
  assign flag_carry    = carry_q;
  assign illegal       = illegal_q;
  assign busy          = (state_q != FETCH);

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer with a behavioural 4-entry register file
// and a write scoreboard checked on every REG_WRITE cycle.
module tb_reg_sequencer;
  import reg_sequencer_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    instr_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    reg_1_in;
  logic [7:0]    reg_2_in;
  registers_op_e reg_op;
  register_sel_e reg_in_sel;
  register_sel_e reg_1_out_sel;
  register_sel_e reg_2_out_sel;
  logic [7:0]    reg_data_out;
  logic          flag_zero;
  logic          flag_carry;
  logic          illegal;
  logic          busy;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] rf [4];
  int         total = 0;
  int         bad   = 0;

  always #5 clock = ~clock;

  reg_sequencer #(
    .DATA_BUS_WIDTH (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .instr_data    (instr_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .reg_1_in      (reg_1_in),
    .reg_2_in      (reg_2_in),
    .reg_op        (reg_op),
    .reg_in_sel    (reg_in_sel),
    .reg_1_out_sel (reg_1_out_sel),
    .reg_2_out_sel (reg_2_out_sel),
    .reg_data_out  (reg_data_out),
    .flag_zero     (flag_zero),
    .flag_carry    (flag_carry),
    .illegal       (illegal),
    .busy          (busy)
  );

  assign reg_1_in = rf[reg_1_out_sel];
  assign reg_2_in = rf[reg_2_out_sel];

  always @(posedge clock)
    if (reg_op == REG_WRITE) rf[reg_in_sel] <= reg_data_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && reg_op === REG_WRITE) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 32'(reg_op), 32'(REG_IDLE));
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_sel", 32'(reg_in_sel), 32'(e.sel));
        chk("wr_data", 32'(reg_data_out), 32'(e.data));
      end
    end
  end

  task automatic push(input logic [1:0] sel, input logic [7:0] data);
    wr_t e;
    e.sel  = sel;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Holds valid until an accepting edge, then drops it 1 time unit later.
  task automatic send(input logic [7:0] d);
    int unsigned n = 0;
    instr_data  = d;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(instr_ready), 32'd1);
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy) && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (n >= 30) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
  endtask

  task automatic ldi(input logic [1:0] rd, input logic [7:0] val);
    push(rd, val);
    send({4'h7, rd, 2'b00});
    send(val);
    wait_idle();
  endtask

  task automatic alu(input logic [7:0] instr, input logic [1:0] rd, input logic [7:0] val);
    push(rd, val);
    send(instr);
    wait_idle();
  endtask

  task automatic flags(input string tag, input logic z, input logic c);
    chk({tag, "_zero"}, 32'(flag_zero), 32'(z));
    chk({tag, "_carry"}, 32'(flag_carry), 32'(c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  rdv;
    logic [7:0]  val;
    int unsigned gap;

    reset       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
    repeat (2) @(negedge clock);
    chk("rst_reg_op", 32'(reg_op), 32'(REG_IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    flags("rst", 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    // Reset while waiting for the LDI immediate aborts the load.
    send(8'h74);
    chk("mid_ldi_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1 chk("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    chk("post_rst_reg_op", 32'(reg_op), 32'(REG_IDLE));
    flags("post_rst", 1'b0, 1'b0);

    // ADD with exact latency and ready low while valid is held.
    ldi(2'd1, 8'h05);
    ldi(2'd2, 8'h03);
    push(2'd1, 8'h08);
    send(8'h26);
    instr_data  = 8'h00;
    instr_valid = 1'b1;
    @(negedge clock);
    chk("exec_reg_op", 32'(reg_op), 32'(REG_IDLE));
    chk("exec_ready", 32'(instr_ready), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("write_reg_op", 32'(reg_op), 32'(REG_WRITE));
    chk("write_ready", 32'(instr_ready), 32'd0);
    chk("write_sel", 32'(reg_in_sel), 32'd1);
    chk("write_data", 32'(reg_data_out), 32'h08);
    @(negedge clock);
    instr_valid = 1'b0;
    wait_idle();
    flags("add", 1'b0, 1'b0);
    chk("rf_r1_add", 32'(rf[1]), 32'h08);

    // Overflow and increment.
    ldi(2'd1, 8'hFF);
    ldi(2'd2, 8'h01);
    alu(8'h26, 2'd1, 8'h00);
    flags("add_ovf", 1'b1, 1'b1);
    alu(8'h84, 2'd1, 8'h01);
    flags("inc", 1'b0, 1'b0);

    // Borrow, then MOV keeps flags.
    ldi(2'd1, 8'h03);
    ldi(2'd2, 8'h05);
    alu(8'h36, 2'd1, 8'hFE);
    flags("sub", 1'b0, 1'b1);
    alu(8'h1D, 2'd3, 8'hFE);
    flags("mov", 1'b0, 1'b1);
    chk("rf_r3_mov", 32'(rf[3]), 32'hFE);

    // Remaining ALU ops.
    alu(8'h94, 2'd1, 8'hFC);
    flags("shl", 1'b0, 1'b1);
    alu(8'h65, 2'd1, 8'h00);
    flags("xor", 1'b1, 1'b0);
    ldi(2'd2, 8'h0F);
    flags("ldi_keeps", 1'b1, 1'b0);
    alu(8'h56, 2'd1, 8'h0F);
    flags("or", 1'b0, 1'b0);
    alu(8'h4E, 2'd3, 8'h0E);
    flags("and", 1'b0, 1'b0);

    // Illegal opcode pulses for one cycle; NOP does nothing.
    send(8'hA0);
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk("illegal_ready", 32'(instr_ready), 32'd1);
    chk("illegal_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1 chk("illegal_end", 32'(illegal), 32'd0);
    send(8'h00);
    chk("nop_illegal", 32'(illegal), 32'd0);
    chk("nop_busy", 32'(busy), 32'd0);
    wait_idle();

    // Back-pressure between LDI opcode and immediate.
    for (int i = 0; i < 3; i++) begin
      rdv = 2'(i);
      val = 8'($urandom_range(1, 255));
      push(rdv, val);
      send({4'h7, rdv, 2'b00});
      instr_data = 8'hEE;
      gap = $urandom_range(1, 4);
      repeat (gap) begin
        @(posedge clock);
        #1 chk("bp_busy", 32'(busy), 32'd1);
      end
      send(val);
      wait_idle();
      chk("bp_rf", 32'(rf[rdv]), 32'(val));
    end

    wait_idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_sequencer.md
Name: reg_sequencer

Overview:
- Initiator side of the register-file interface: accepts 8-bit instructions over a valid/ready handshake and decodes them.
- Drives the register file's write port and both read-select ports, computes results with a small ALU, and writes back.
- Sits between the instruction source and the register file; one instruction completes per 1–3 cycles.

Parameters:
- DATA_BUS_WIDTH, 8, register/data width; must be >= 8. The instruction occupies instr_data[7:0].

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- instr_data  input  DATA_BUS_WIDTH  instruction byte or LDI immediate
- instr_valid  input  1  instr_data valid
- instr_ready  output  1  sequencer accepts instr_data this cycle
- reg_1_in  input  DATA_BUS_WIDTH  register file read port 1 data
- reg_2_in  input  DATA_BUS_WIDTH  register file read port 2 data
- reg_op  output  registers_op_e  REG_WRITE or REG_IDLE
- reg_in_sel  output  register_sel_e  write-target select
- reg_1_out_sel  output  register_sel_e  read port 1 select (rd)
- reg_2_out_sel  output  register_sel_e  read port 2 select (rs)
- reg_data_out  output  DATA_BUS_WIDTH  write data
- flag_zero  output  1  registered zero flag
- flag_carry  output  1  registered carry/borrow flag
- illegal  output  1  one-cycle pulse on undefined opcode
- busy  output  1  high when state != FETCH

Behaviour:
- Reset is asynchronous, active-low, on reset; clock is clock.
- Reset values: state=FETCH, reg_op=REG_IDLE, instr_q=0, result_q=0, flags=0, illegal=0. A reset asserted mid-instruction aborts it; no write is issued.
- Instruction encoding: [7:4] opcode, [3:2] rd, [1:0] rs.
  - 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 LDI, 8 INC, 9 SHL.
  - Opcodes 10–15 are illegal.
- Handshake: a transfer occurs on a clock edge with instr_valid && instr_ready. instr_ready is high only in FETCH and IMM. instr_data is ignored without valid.
- reg_1_out_sel=instr_q.rd and reg_2_out_sel=instr_q.rs at all times; selects are stable from the cycle after accept.
- FETCH:
  - On transfer, latch instr_q.
  - Next state is EXEC for opcodes 1–6, 8, 9; IMM for 7.
  - For 0, stay in FETCH with no write.
  - For illegal opcodes, stay in FETCH and pulse illegal high for exactly the following cycle.
- IMM: wait for the next transfer; result_q <= instr_data[DATA_BUS_WIDTH-1:0]; go to WRITE.
- EXEC: compute the result from reg_1_in (rd) and reg_2_in (rs); result_q <= result; next-flag values are latched; go to WRITE.
- ALU rules at width W=DATA_BUS_WIDTH, computed at W+1 bits:
  - MOV: rs.
  - ADD: rd+rs; carry = bit W.
  - SUB: rd-rs; carry=1 on borrow (rd<rs).
  - AND/OR/XOR: carry=0.
  - INC: rd+1; carry = bit W.
  - SHL: rd<<1; carry = rd[W-1].
  - All results are truncated to W bits.
- WRITE: drive reg_op=REG_WRITE, reg_in_sel=instr_q.rd, reg_data_out=result_q for exactly one cycle; then go to FETCH.
  - In the same edge, flags update for ALU ops (2–6, 8, 9): zero = (result_q==0), carry as above.
  - MOV and LDI leave flags unchanged.
- reg_op=REG_IDLE in every state other than WRITE.
- Latency: accept at edge N → EXEC in cycle N+1 → WRITE in N+2 → register updated at end of N+2 → next accept possible at edge N+3. LDI takes 2 transfers, then WRITE.
- rd==rs is legal; operands are read before the write.
- Back-to-back dependency needs no forwarding: the write completes before the next read.

Decomposition:
- The shared package keeps registers_op_e (REG_IDLE, REG_WRITE) and register_sel_e.
- Add to the package: seq_opcode_e (4-bit), seq_state_e (FETCH, IMM, EXEC, WRITE), and the instruction field positions as constants.
- Sub-module seq_alu: purely combinational. Inputs are opcode, a, b; outputs are result and carry.
- reg_sequencer holds the FSM, instr_q, result_q and flags.

Test Plan:
- Reset mid-LDI: send 0x74, assert reset before the immediate → reg_op never REG_WRITE, busy=0, instr_ready=1 after release, flags 0.
- Send LDI R1 (0x74)+0x05, LDI R2 (0x78)+0x03, ADD R1,R2 (0x26) → WRITE to sel 1 with 0x08 exactly 2 cycles after the ADD accept; zero=0, carry=0.
- Overflow: R1=0xFF, R2=0x01, ADD (0x26) → write 0x00, zero=1, carry=1. Then INC R1 (0x84) → 0x01, zero=0, carry=0.
- Borrow: R1=0x03, R2=0x05, SUB (0x36) → write 0xFE, carry=1. Then MOV R3,R1 (0x1D) → R3=0xFE, flags unchanged.
- Illegal 0xA0 → illegal high exactly one cycle, no write, instr_ready stays 1; NOP 0x00 → no write, no pulse.
- Back-pressure: deassert instr_valid randomly between the LDI opcode and its immediate → no spurious accept; the correct immediate is written. Also check instr_ready=0 in EXEC/WRITE while valid is held high.
